// File: rtl/ref_bank_mem_pkg.sv
// Shared types and helpers for the N-bank reference memory.
package ref_bank_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

  function automatic int unsigned bank_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] clamp_len(input logic [63:0] len, input int unsigned ptr_w);
    logic [63:0] depth;
    depth = 64'd1 << ptr_w;
    return (len > depth) ? depth : len;
  endfunction

  function automatic logic len_over(input logic [63:0] len, input int unsigned ptr_w);
    return len > (64'd1 << ptr_w);
  endfunction

endpackage

// File: rtl/ref_bank_mem_dtw_mem.sv
// Single-port reference bank: synchronous write, registered read.
module dtw_mem #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned PTR_WIDTH = 15,
  parameter int unsigned REF_INIT  = 0
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [PTR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout
);

  localparam int unsigned DEPTH = 1 << PTR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH] = '{default: WIDTH'(REF_INIT)};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/ref_bank_mem.sv
// Round-robin ring of reference banks: FIFO loader on wr_ptr, consumer reads rd_ptr.
module ref_bank_mem
  import ref_bank_mem_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned AXIS_WIDTH  = 32,
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned PTR_WIDTH   = 15,
  parameter int unsigned RELEASE_CNT = 8,
  parameter int unsigned REF_INIT    = 0,
  localparam int unsigned BANK_IDX_W = bank_idx_w(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_cmd,
  input  logic [AXIS_WIDTH-1:0] ref_len,
  output logic                  src_fifo_clear,
  output logic                  src_fifo_rden,
  input  logic                  src_fifo_empty,
  input  logic [AXIS_WIDTH-1:0] src_fifo_data,
  input  logic                  ref_mem_read,
  input  logic [PTR_WIDTH-1:0]  ref_read_addr,
  output logic [WIDTH-1:0]      dataout_ref,
  output logic [AXIS_WIDTH-1:0] ref_len_out,
  output logic [BANK_IDX_W-1:0] rd_bank,
  output logic                  mem_busy,
  output logic                  ref_load_done,
  output logic                  load_err,
  output logic [PTR_WIDTH-1:0]  dbug_ref_mem_write_addr,
  output logic [1:0]            dbug_ref_load_state
);

  localparam int unsigned CNT_W  = PTR_WIDTH + 1;
  localparam int unsigned PASS_W = (RELEASE_CNT > 1) ? $clog2(RELEASE_CNT) : 1;

  load_state_t state, state_nxt;

  logic [NUM_BANKS-1:0]  valid;
  logic [AXIS_WIDTH-1:0] len [NUM_BANKS];
  logic [BANK_IDX_W-1:0] wr_ptr, rd_ptr, rd_ptr_q;
  logic [CNT_W-1:0]      wr_cnt, eff_len;
  logic [PASS_W-1:0]     pass_cnt;
  logic [1:0]            read_d;
  logic                  accept, wr_en, pass_edge;
  logic [WIDTH-1:0]      bank_dout [NUM_BANKS];
  logic                  unused_data;

  assign unused_data = ^src_fifo_data;

  function automatic logic [BANK_IDX_W-1:0] next_bank(input logic [BANK_IDX_W-1:0] p);
    return (p == BANK_IDX_W'(NUM_BANKS - 1)) ? '0 : p + BANK_IDX_W'(1);
  endfunction

  assign wr_en     = (state == ST_LOAD) && (wr_cnt < eff_len) && !src_fifo_empty;
  assign pass_edge = read_d[1] && !read_d[0];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Leave LOAD on the cycle the last word is written so an L-word load spends L cycles there.
  always_comb begin
    state_nxt      = state;
    src_fifo_clear = 1'b0;
    src_fifo_rden  = 1'b0;
    accept         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        src_fifo_clear = 1'b1;
        if (load_cmd && !valid[wr_ptr]) begin
          accept    = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        src_fifo_rden = wr_cnt < eff_len;
        if ((wr_cnt == eff_len) || (wr_en && ((wr_cnt + CNT_W'(1)) == eff_len)))
          state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      len      <= '{default: '0};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_ptr_q <= '0;
      wr_cnt   <= '0;
      eff_len  <= '0;
      load_err <= 1'b0;
      pass_cnt <= '0;
      read_d   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr;
      read_d   <= {read_d[0], ref_mem_read};
      if (accept) begin
        eff_len  <= CNT_W'(clamp_len(64'(ref_len), PTR_WIDTH));
        load_err <= len_over(64'(ref_len), PTR_WIDTH);
        wr_cnt   <= '0;
      end else if (wr_en) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
      if (state == ST_DONE) begin
        valid[wr_ptr] <= 1'b1;
        len[wr_ptr]   <= AXIS_WIDTH'(eff_len);
        wr_ptr        <= next_bank(wr_ptr);
      end
      // DONE only targets an invalid bank, and release only a valid one, so they never collide.
      if (pass_edge && valid[rd_ptr]) begin
        if (pass_cnt == PASS_W'(RELEASE_CNT - 1)) begin
          valid[rd_ptr] <= 1'b0;
          rd_ptr        <= next_bank(rd_ptr);
          pass_cnt      <= '0;
        end else begin
          pass_cnt <= pass_cnt + PASS_W'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                 is_wr;
    logic [PTR_WIDTH-1:0] addr;
    assign is_wr = (wr_ptr == BANK_IDX_W'(b));
    assign addr  = (state == ST_LOAD && is_wr) ? wr_cnt[PTR_WIDTH-1:0] : ref_read_addr;
    dtw_mem #(
      .WIDTH     (WIDTH),
      .PTR_WIDTH (PTR_WIDTH),
      .REF_INIT  (REF_INIT)
    ) u_mem (
      .clk  (clk),
      .we   (wr_en && is_wr),
      .addr (addr),
      .din  (src_fifo_data[WIDTH-1:0]),
      .dout (bank_dout[b])
    );
  end

  assign dataout_ref             = bank_dout[rd_ptr_q];
  assign ref_len_out             = len[rd_ptr];
  assign rd_bank                 = rd_ptr;
  assign mem_busy                = &valid;
  assign ref_load_done           = valid[rd_ptr];
  assign dbug_ref_mem_write_addr = wr_cnt[PTR_WIDTH-1:0];
  assign dbug_ref_load_state     = state;

endmodule

// File: tb/tb_ref_bank_mem.sv
// Directed bench for ref_bank_mem with a small FWFT FIFO model (4 banks, 16-word banks).
module tb_ref_bank_mem;

  logic        clk = 1'b0;
  logic        rst, load_cmd, src_fifo_empty, ref_mem_read;
  logic [31:0] ref_len, src_fifo_data, ref_len_out;
  logic        src_fifo_clear, src_fifo_rden, mem_busy, ref_load_done, load_err;
  logic [3:0]  ref_read_addr, dbug_ref_mem_write_addr;
  logic [15:0] dataout_ref;
  logic [1:0]  rd_bank, dbug_ref_load_state;

  logic [31:0] fifo_q[$];
  logic        stall = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ref_bank_mem #(
    .WIDTH       (16),
    .AXIS_WIDTH  (32),
    .NUM_BANKS   (4),
    .PTR_WIDTH   (4),
    .RELEASE_CNT (8),
    .REF_INIT    (0)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .load_cmd                (load_cmd),
    .ref_len                 (ref_len),
    .src_fifo_clear          (src_fifo_clear),
    .src_fifo_rden           (src_fifo_rden),
    .src_fifo_empty          (src_fifo_empty),
    .src_fifo_data           (src_fifo_data),
    .ref_mem_read            (ref_mem_read),
    .ref_read_addr           (ref_read_addr),
    .dataout_ref             (dataout_ref),
    .ref_len_out             (ref_len_out),
    .rd_bank                 (rd_bank),
    .mem_busy                (mem_busy),
    .ref_load_done           (ref_load_done),
    .load_err                (load_err),
    .dbug_ref_mem_write_addr (dbug_ref_mem_write_addr),
    .dbug_ref_load_state     (dbug_ref_load_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_refresh();
    src_fifo_empty = stall || (fifo_q.size() == 0);
    src_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hdead_beef;
  endtask

  // One clock: the FIFO pops if the DUT acknowledges a present word; sample #1 after the edge.
  task automatic step();
    logic pop_now;
    pop_now = src_fifo_rden && !src_fifo_empty;
    @(posedge clk);
    #1;
    if (pop_now) void'(fifo_q.pop_front());
    fifo_refresh();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, dbug_ref_load_state, 2'd0);
    check({tag, "_clear"}, src_fifo_clear, 1'b1);
    check({tag, "_rden"}, src_fifo_rden, 1'b0);
    check({tag, "_busy"}, mem_busy, 1'b0);
    check({tag, "_done"}, ref_load_done, 1'b0);
    check({tag, "_err"}, load_err, 1'b0);
    check({tag, "_len"}, ref_len_out, 32'd0);
    check({tag, "_rdbank"}, rd_bank, 2'd0);
    check({tag, "_waddr"}, dbug_ref_mem_write_addr, 4'd0);
  endtask

  task automatic do_load(input string tag, input int len, input int n_push, input int base,
                         input int stall_at, output int pops, output int rden_cyc, output int load_cyc);
    int guard;
    logic [3:0] hold;
    for (int i = 0; i < n_push; i++) fifo_q.push_back(32'(base + i));
    fifo_refresh();
    ref_len  = 32'(len);
    load_cmd = 1'b1;
    step();
    load_cmd = 1'b0;
    check({tag, "_accept"}, dbug_ref_load_state, 2'd1);
    pops = 0; rden_cyc = 0; load_cyc = 0; guard = 0;
    while (dbug_ref_load_state == 2'd1 && guard < 200) begin
      if (load_cyc == stall_at) begin
        stall = 1'b1;
        fifo_refresh();
        hold = dbug_ref_mem_write_addr;
        for (int s = 0; s < 3; s++) begin
          step();
          check({tag, "_stall_hold"}, dbug_ref_mem_write_addr, hold);
        end
        stall = 1'b0;
        fifo_refresh();
      end
      load_cyc++;
      if (src_fifo_rden) rden_cyc++;
      if (src_fifo_rden && !src_fifo_empty) pops++;
      step();
      guard++;
    end
    check({tag, "_done_state"}, dbug_ref_load_state, 2'd2);
    step();
    check({tag, "_idle"}, dbug_ref_load_state, 2'd0);
  endtask

  task automatic do_passes(input int n);
    for (int p = 0; p < n; p++) begin
      ref_mem_read = 1'b1;
      step(); step();
      ref_mem_read = 1'b0;
      repeat (4) step();
    end
  endtask

  task automatic read_check(input string tag, input int addr, input int exp);
    ref_read_addr = 4'(addr);
    step();
    check(tag, dataout_ref, 16'(exp));
  endtask

  initial begin
    int pops, rcyc, lcyc, guard;
    rst = 1'b1; load_cmd = 1'b0; ref_len = '0; ref_mem_read = 1'b0; ref_read_addr = '0;
    fifo_refresh();
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // 5 words 1..5 into bank 0
    do_load("len5", 5, 5, 1, -1, pops, rcyc, lcyc);
    check("len5_pops", pops, 5);
    check("len5_load_cycles", lcyc, 5);
    check("len5_rden_after", src_fifo_rden, 1'b0);
    check("len5_done", ref_load_done, 1'b1);
    check("len5_len", ref_len_out, 32'd5);
    check("len5_err", load_err, 1'b0);
    for (int a = 0; a < 5; a++) read_check("len5_read", a, a + 1);
    do_passes(1);
    check("len5_one_pass_kept", ref_load_done, 1'b1);
    check("len5_one_pass_rdbank", rd_bank, 2'd0);

    // zero length into bank 1
    do_load("len0", 0, 0, 0, -1, pops, rcyc, lcyc);
    check("len0_rden_cycles", rcyc, 0);
    check("len0_load_cycles", lcyc, 1);
    check("len0_err", load_err, 1'b0);

    // over-length into bank 2: clamped to 16
    do_load("len20", 20, 20, 'h100, -1, pops, rcyc, lcyc);
    check("len20_pops", pops, 16);
    check("len20_err", load_err, 1'b1);
    check("len20_busy", mem_busy, 1'b0);
    fifo_q.delete();
    fifo_refresh();

    // 6 words into bank 3 with a 3-cycle empty stall after 2 words
    do_load("stall", 6, 6, 'h200, 2, pops, rcyc, lcyc);
    check("stall_pops", pops, 6);
    check("stall_busy", mem_busy, 1'b1);

    // all banks full: request must wait
    for (int i = 0; i < 3; i++) fifo_q.push_back(32'('h300 + i));
    fifo_refresh();
    ref_len = 32'd3; load_cmd = 1'b1;
    repeat (5) step();
    check("full_wait_state", dbug_ref_load_state, 2'd0);
    check("full_wait_fifo", fifo_q.size(), 3);
    do_passes(6);
    check("full_7pass_rdbank", rd_bank, 2'd0);
    do_passes(1);
    check("full_8pass_rdbank", rd_bank, 2'd1);
    guard = 0;
    while (!(mem_busy && dbug_ref_load_state == 2'd0) && guard < 50) begin
      step();
      guard++;
    end
    load_cmd = 1'b0;
    check("pending_busy", mem_busy, 1'b1);
    check("pending_fifo_drained", fifo_q.size(), 0);
    check("pending_err", load_err, 1'b0);
    check("bank1_done", ref_load_done, 1'b1);
    check("bank1_len", ref_len_out, 32'd0);

    do_passes(8);
    check("bank2_rdbank", rd_bank, 2'd2);
    check("bank2_len", ref_len_out, 32'd16);
    read_check("bank2_read0", 0, 'h100);
    read_check("bank2_read15", 15, 'h10F);

    do_passes(8);
    check("bank3_rdbank", rd_bank, 2'd3);
    check("bank3_len", ref_len_out, 32'd6);
    for (int a = 0; a < 6; a++) read_check("bank3_read", a, 'h200 + a);

    do_passes(8);
    check("bank0_rdbank", rd_bank, 2'd0);
    check("bank0_len", ref_len_out, 32'd3);
    for (int a = 0; a < 3; a++) read_check("bank0_read", a, 'h300 + a);

    // reset in the middle of a stalled load into bank 1
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'('h350 + i));
    stall = 1'b1;
    fifo_refresh();
    ref_len = 32'd4; load_cmd = 1'b1;
    step();
    load_cmd = 1'b0;
    step();
    check("midrst_in_load", dbug_ref_load_state, 2'd1);
    rst = 1'b1;
    step();
    check_reset_outputs("midrst");
    rst = 1'b0;
    stall = 1'b0;
    fifo_q.delete();
    fifo_refresh();
    step();

    do_load("after_rst", 2, 2, 'h400, -1, pops, rcyc, lcyc);
    check("after_rst_done", ref_load_done, 1'b1);
    check("after_rst_len", ref_len_out, 32'd2);
    read_check("after_rst_read0", 0, 'h400);
    read_check("after_rst_read1", 1, 'h401);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
